// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Parametrised up/down counter with a runtime modulo limit (range 0..limit),
//   a synchronous load, and wrap or one-shot operation. It produces a
//   registered one-cycle terminal-count pulse (tc) and a sticky completion flag
//   (done) for one-shot runs.
//
//   Optional build macro: COUNTER_PRESCALE_EN
//     When defined, an internal PRESCALE_W-bit divider lets one step through
//     per (presc+1) enabled cycles. When undefined, every enabled, non-load
//     cycle is a step and presc is ignored.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous reset, active high
//   en        in   count enable
//   load      in   synchronous load strobe (takes priority over stepping)
//   load_val  in   [WIDTH]       load value, clamped to limit
//   up        in   direction, 1 = increment, 0 = decrement
//   limit     in   [WIDTH]       modulo top of the count range
//   one_shot  in   0 = wrap at the boundary, 1 = stop and raise done
//   presc     in   [PRESCALE_W]  step divisor minus one (prescale build only)
//   count     out  [WIDTH]       current count, registered
//   tc        out  terminal-count pulse, registered, one cycle per event
//   done      out  sticky one-shot completion flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  up,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  one_shot,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  logic             step_qual;
  logic             at_boundary;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] div_q;

  // Equality compare (not >=) so a newly written presc is picked up at the
  // next time the divider reaches it.
  assign step_qual = (div_q == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= '0;
    end else if (en) begin
      if (step_qual) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + PRESCALE_W'(1);
      end
    end
  end
`else
  logic unused_presc;

  assign unused_presc = ^presc;
  assign step_qual    = 1'b1;
`endif

  // Up mode uses >= so that a limit lowered below the current count still
  // produces a boundary event on the next up step.
  assign at_boundary  = up ? (count >= limit) : (count == '0);
  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (en && step_qual) begin
      if (done) begin
        // Completed one-shot stays frozen even if one_shot is dropped.
        tc <= 1'b0;
      end else if (!at_boundary) begin
        count <= up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        tc    <= 1'b0;
      end else if (one_shot) begin
        done <= 1'b1;
        tc   <= 1'b1;
      end else begin
        count <= up ? '0 : limit;
        tc    <= 1'b1;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//   Scoreboarded bench for mod_updown_counter (WIDTH=8, PRESCALE_W=4).
//   The driver applies inputs on the falling edge, advances a behavioural
//   model and queues the expected outputs; the monitor pops one entry after
//   each rising edge and compares. Directed plan items queue literal values.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, up, one_shot;
  logic [7:0] load_val, limit;
  logic [3:0] presc;
  logic [7:0] count;
  logic       tc, done;

  mod_updown_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .limit    (limit),
    .one_shot (one_shot),
    .presc    (presc),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       t;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // behavioural model state
  int m_count = 0;
  bit m_tc    = 0;
  bit m_done  = 0;
  int m_div   = 0;

  task automatic model_reset();
    m_count = 0;
    m_tc    = 0;
    m_done  = 0;
    m_div   = 0;
  endtask

  task automatic model_step(input bit i_en, input bit i_load, input int i_lv,
                            input bit i_up, input int i_lim, input bit i_os,
                            input int i_presc);
    bit qual;
    bit bnd;
    if (i_load) begin
      m_count = (i_lv > i_lim) ? i_lim : i_lv;
      m_tc    = 0;
      m_done  = 0;
      m_div   = 0;
    end else begin
      qual = i_en;
`ifdef COUNTER_PRESCALE_EN
      if (i_en) begin
        qual  = (m_div == i_presc);
        m_div = qual ? 0 : (m_div + 1) % 16;
      end
`endif
      if (qual) begin
        bnd = i_up ? (m_count >= i_lim) : (m_count == 0);
        if (m_done) begin
          m_tc = 0;
        end else if (!bnd) begin
          m_count = i_up ? m_count + 1 : m_count - 1;
          m_tc    = 0;
        end else if (i_os) begin
          m_done = 1;
          m_tc   = 1;
        end else begin
          m_count = i_up ? 0 : i_lim;
          m_tc    = 1;
        end
      end else begin
        m_tc = 0;
      end
    end
  endtask

  // Apply one cycle of stimulus. With lit=1 the given literal outputs are
  // queued instead of the model's (the model still advances).
  task automatic drive(input bit i_en, input bit i_load, input int i_lv,
                       input bit i_up, input int i_lim, input bit i_os,
                       input int i_presc, input bit lit, input int lc,
                       input bit lt, input bit ld);
    exp_t e;
    @(negedge clk);
    en       = i_en;
    load     = i_load;
    load_val = 8'(i_lv);
    up       = i_up;
    limit    = 8'(i_lim);
    one_shot = i_os;
    presc    = 4'(i_presc);
    model_step(i_en, i_load, i_lv, i_up, i_lim, i_os, i_presc);
    if (lit) e = '{c: 8'(lc), t: lt, d: ld};
    else     e = '{c: 8'(m_count), t: m_tc, d: m_done};
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (count !== e.c || tc !== e.t || done !== e.d) begin
          n_miss++;
          $display("FAIL scoreboard: got count=%0h tc=%0b done=%0b, expected count=%0h tc=%0b done=%0b at %0t",
                   count, tc, done, e.c, e.t, e.d, $time);
        end
      end
    end
  end

  initial begin
    int dn[4];
    int pc[11];
    int pe[11];
    int r_lim;
    bit r_os;
    int guard;

    dn = '{1, 0, 5, 4};
    pe = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    pc = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    rst = 1'b1; en = 0; load = 0; load_val = 0; up = 1;
    limit = 0; one_shot = 0; presc = 0;
    repeat (2) @(negedge clk);
    check_now("reset_count", int'(count), 0);
    check_now("reset_tc", int'(tc), 0);
    check_now("reset_done", int'(done), 0);
    rst = 1'b0;
    model_reset();

    // wrap up, limit 9
    drive(0, 1, 0, 1, 9, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      drive(1, 0, 0, 1, 9, 0, 0, 1, i % 10, (i == 10), 0);

    // wrap down, limit 5 from 2
    drive(0, 1, 2, 0, 5, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 0, 0, 0, 5, 0, 0, 1, dn[i], (i == 2), 0);

    // one-shot, limit 3
    drive(0, 1, 0, 1, 3, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++)
      drive(1, 0, 0, 1, 3, 1, 0, 1, (i < 3) ? i : 3, (i == 4), (i >= 4));
    drive(0, 0, 0, 1, 3, 0, 0, 1, 3, 0, 1);  // one_shot dropped: done sticks
    drive(1, 0, 0, 1, 3, 0, 0, 1, 3, 0, 1);
    drive(0, 1, 0, 1, 3, 1, 0, 1, 0, 0, 0);

    // limit 0 wrap: tc on every enabled step
    drive(1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    // load edge cases
    drive(0, 1, 8'hF0, 1, 8'h20, 0, 0, 1, 8'h20, 0, 0);
    drive(1, 1, 8'h05, 1, 8'hFF, 0, 0, 1, 8'h05, 0, 0);
    drive(0, 1, 8'h40, 1, 8'hFF, 0, 0, 1, 8'h40, 0, 0);
    drive(1, 0, 0, 1, 8'h10, 0, 0, 1, 0, 1, 0);
    drive(0, 1, 8'h40, 1, 8'hFF, 0, 0, 1, 8'h40, 0, 0);
    drive(1, 0, 0, 0, 8'h10, 0, 0, 1, 8'h3F, 0, 0);  // down step decrements

    // reset pulse between edges at count 0x37
    drive(0, 1, 8'h37, 1, 8'hFF, 0, 0, 1, 8'h37, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("rst_mid_count", int'(count), 0);
    check_now("rst_mid_tc", int'(tc), 0);
    check_now("rst_mid_done", int'(done), 0);
    en = 1;
    @(negedge clk);
    check_now("rst_hold_count", int'(count), 0);
    rst = 1'b0;
    en  = 0;
    model_reset();

`ifdef COUNTER_PRESCALE_EN
    // presc=2, with a 2-cycle enable gap
    drive(0, 1, 0, 1, 8'hFF, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      drive(pe[i] != 0, 0, 0, 1, 8'hFF, 0, 2, 1, pc[i], 0, 0);
`else
    // presc ignored: every enabled cycle steps
    drive(0, 1, 0, 1, 8'hFF, 0, 2, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      drive(1, 0, 0, 1, 8'hFF, 0, 2, 1, i, 0, 0);
`endif

    // randomized run against the model
    r_lim = 9;
    r_os  = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: r_lim = 0;
          1: r_lim = $urandom_range(1, 6);
          2: r_lim = $urandom_range(0, 255);
          default: r_lim = 255;
        endcase
      end
      if ($urandom_range(0, 29) == 0) r_os = ~r_os;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 255), $urandom_range(0, 7) != 0, r_lim, r_os,
            $urandom_range(0, 3), 0, 0, 0, 0);
    end

    @(negedge clk);
    en = 0; load = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
